// File: rtl/lif_pkg.sv
// lif_pkg: shared types and helpers for the sequential LIF neuron.
//   state_t          - FSM states of lif_neuron_seq
//   acc_width()      - width of the serial weight accumulator
//   sat_add()        - add two values and saturate to a signed 'width'-bit range
//   leak_toward_zero - move a value toward zero by 'leak' without crossing it
// The arithmetic helpers work on 64-bit signed values so callers can sign-extend
// any narrower operand and truncate the (already saturated) result back.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    UPDATE
  } state_t;

  // One bit per doubling of the input count plus one sign-growth bit: the sum of
  // NUM_INPUTS W_W-bit signed weights always fits.
  function automatic int acc_width(input int w_w, input int num_inputs);
    return w_w + $clog2(num_inputs) + 1;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v)      return max_v;
    else if (sum < min_v) return min_v;
    else                  return sum;
  endfunction

  // 'leak' is a non-negative magnitude.
  function automatic logic signed [63:0] leak_toward_zero(input logic signed [63:0] v,
                                                          input logic signed [63:0] leak);
    if (v > 0)      return (v > leak) ? v - leak : 64'sd0;
    else if (v < 0) return (-v > leak) ? v + leak : 64'sd0;
    else            return 64'sd0;
  endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update: combinational UPDATE datapath of the LIF neuron for a
// non-refractory step: leak toward zero, saturating integrate, threshold
// compare and post-spike reset.
//   v          in  current membrane potential (signed)
//   acc        in  accumulated weighted input of this step (signed)
//   threshold  in  firing threshold (signed)
//   leak       in  leak magnitude (unsigned)
//   reset_mode in  0 = reset to zero on fire, 1 = subtract threshold
//   v_next     out membrane potential after this step
//   fire       out 1 when the integrated potential reached the threshold
module lif_update
  import lif_pkg::*;
#(
  parameter int V_W   = 16,
  parameter int ACC_W = 12
) (
  input  logic signed [V_W-1:0]   v,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [V_W-1:0]   threshold,
  input  logic        [V_W-1:0]   leak,
  input  logic                    reset_mode,
  output logic signed [V_W-1:0]   v_next,
  output logic                    fire
);

  logic signed [63:0] v_leaked;
  logic signed [63:0] v_int;
  logic signed [63:0] v_sub;

  // NOTE: every output of an always_comb gets a value on every path (here
  // before any branch), otherwise synthesis infers a latch.
  always_comb begin
    v_next   = '0;
    v_leaked = leak_toward_zero(64'(v), signed'(64'(leak)));
    v_int    = sat_add(v_leaked, 64'(acc), V_W);
    fire     = (v_int >= 64'(threshold));
    // v_int >= threshold here, but a negative threshold can still push the
    // difference past the positive limit, hence the saturating subtract.
    v_sub    = sat_add(v_int, -64'(threshold), V_W);
    if (fire) v_next = reset_mode ? V_W'(v_sub) : '0;
    else      v_next = V_W'(v_int);
  end

endmodule

// File: rtl/lif_neuron_seq.sv
// lif_neuron_seq: sequential leaky-integrate-and-fire neuron.
// A timestep is accepted under step_valid/step_ready, the weighted spikes are
// summed one synapse per cycle, then a single UPDATE cycle applies leak,
// integration, threshold and refractory logic. One step takes NUM_INPUTS+2
// cycles from accept to out_valid.
//   clk, reset      clock; synchronous active-high reset
//   step_valid/ready timestep handshake (ready only in IDLE)
//   spike_in        input spikes, bit i = synapse i
//   weights         packed signed weights, synapse i at [i*W_W +: W_W]
//   threshold       signed firing threshold
//   leak            unsigned leak magnitude per step
//   tref            refractory steps after a spike
//   reset_mode      0 = reset to zero, 1 = subtract threshold
//   v_out           membrane potential after the last completed step
//   spike_out       spike result of the last completed step
//   out_valid       one-cycle pulse when a step completes
module lif_neuron_seq
  import lif_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int W_W        = 8,
  parameter int V_W        = 16,
  parameter int TREF_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step_valid,
  output logic                      step_ready,
  input  logic [NUM_INPUTS-1:0]     spike_in,
  input  logic [NUM_INPUTS*W_W-1:0] weights,
  input  logic signed [V_W-1:0]     threshold,
  input  logic [V_W-1:0]            leak,
  input  logic [TREF_W-1:0]         tref,
  input  logic                      reset_mode,
  output logic signed [V_W-1:0]     v_out,
  output logic                      spike_out,
  output logic                      out_valid
);

  localparam int ACC_W = acc_width(W_W, NUM_INPUTS);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  state_t state, state_next;

  logic [NUM_INPUTS-1:0]     spike_q;
  logic [NUM_INPUTS*W_W-1:0] weights_q;
  logic signed [V_W-1:0]     threshold_q;
  logic [V_W-1:0]            leak_q;
  logic [TREF_W-1:0]         tref_q;
  logic                      mode_q;

  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   term;
  logic signed [W_W-1:0]     w_sel;
  logic [TREF_W-1:0]         ref_cnt;

  logic signed [V_W-1:0]     upd_v;
  logic                      upd_fire;

  wire last_idx = (idx == IDX_W'(NUM_INPUTS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (step_valid) state_next = ACCUM;
      ACCUM:   if (last_idx)   state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign step_ready = (state == IDLE);

  always_comb begin
    w_sel = weights_q[idx*W_W +: W_W];
    term  = spike_q[idx] ? ACC_W'(w_sel) : '0;
  end

  lif_update #(
    .V_W   (V_W),
    .ACC_W (ACC_W)
  ) u_update (
    .v          (v_out),
    .acc        (acc),
    .threshold  (threshold_q),
    .leak       (leak_q),
    .reset_mode (mode_q),
    .v_next     (upd_v),
    .fire       (upd_fire)
  );

  // NOTE: the latched step parameters are deliberately left out of reset;
  // they are always rewritten on accept before anything reads them.
  always_ff @(posedge clk) begin
    if (step_ready && step_valid) begin
      spike_q     <= spike_in;
      weights_q   <= weights;
      threshold_q <= threshold;
      leak_q      <= leak;
      tref_q      <= tref;
      mode_q      <= reset_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      acc       <= '0;
      v_out     <= '0;
      ref_cnt   <= '0;
      spike_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (step_valid) begin
            acc <= '0;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + term;
          idx <= idx + IDX_W'(1);
        end
        UPDATE: begin
          out_valid <= 1'b1;
          if (ref_cnt != '0) begin
            // Refractory: potential frozen, accumulated input dropped.
            ref_cnt   <= ref_cnt - TREF_W'(1);
            spike_out <= 1'b0;
          end else begin
            v_out     <= upd_v;
            spike_out <= upd_fire;
            if (upd_fire) ref_cnt <= tref_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
